memory_server: RTL and testbench
================================

Name: memory_server

Overview:
- Downstream endpoint of the processor memory request interface.
- Accepts one request at a time from a requester (fetch or load/store unit) and models a byte-addressed, little-endian on-chip RAM with programmable fixed latency.
- Serves loads and stores of byte, halfword and word size.
- Used as the backing store in simulation and as the synthesizable scratch RAM in small configurations.

Parameters:
- XLEN, 32, data/address width; must match the requester.
- MEM_BYTES, 4096, RAM size in bytes; power of two, ≥ 4.
- LATENCY, 2, cycles from accept to req_fulfilled; ≥ 1.
- INIT_FILE, "", hex image loaded with $readmemh at time 0 when non-empty.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- req_address  input  XLEN  byte address.
- req_operation  input  memory_operation_e  LOAD / STORE.
- req_size  input  memory_operation_size_e  BYTE / HALF / WORD.
- req_store_word  input  XLEN  store data, right-justified.
- req_valid  input  1  request present.
- req_loaded_word  output  XLEN  load data, zero-extended, right-justified.
- req_fulfilled  output  1  one-cycle completion pulse.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset is asynchronous and active-low, rst_n.
  - The server side drives req_loaded_word and req_fulfilled; the requester drives everything else.
- Reset:
  - State goes to IDLE.
  - req_fulfilled = 0, req_loaded_word = 0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on a rising edge with req_valid=1, latch address, operation, size and store word.
    - LATENCY = 1: go to RESP.
    - LATENCY > 1: go to WAIT with counter = LATENCY-2.
  - WAIT: decrement the counter each cycle; at 0, go to RESP.
  - RESP: req_fulfilled=1 for exactly this cycle; the store commits at the end of this cycle; go to IDLE.
- Timing:
  - req_valid high in cycle 0 (accepted) gives req_fulfilled high in cycle LATENCY.
  - Earliest next accept is cycle LATENCY+1, so max throughput is one request per LATENCY+1 cycles.
  - req_valid is ignored in WAIT and RESP.
- Handshake:
  - The requester holds fields stable while req_valid=1 until it sees req_fulfilled.
  - A requester keeping req_valid high after req_fulfilled presents the next request, which is sampled in IDLE.
  - Field changes or req_valid deassertion after accept are ignored; an accepted request always completes (no abort).
- Addressing:
  - RAM index = req_address mod MEM_BYTES (upper bits ignored; wraps).
  - A word access at MEM_BYTES-4 uses bytes MEM_BYTES-4..MEM_BYTES-1; no cross-boundary wrap occurs for aligned accesses.
- Loads:
  - req_loaded_word is updated in the RESP cycle.
  - BYTE: bits[7:0] = mem[a], rest 0.
  - HALF: {mem[a+1], mem[a]}, zero-extended.
  - WORD: {mem[a+3], …, mem[a]}.
  - Held stable until the next load completes; stores leave it unchanged.
- Stores: write only the addressed bytes, taken from the low bits of the latched store word.
- Alignment:
  - Misaligned means HALF with a[0]=1, or WORD with a[1:0]≠0.
  - Without the optional feature, the low address bits are forced to 0 (access aligned down).
- Reset mid-operation: return to IDLE, no req_fulfilled, the pending store is discarded, RAM is unchanged.

Optional Feature:
- Macro: MEMORY_SERVER_MISALIGN_ERR_EN.
- Defined:
  - Adds output req_error (1 bit, reset 0), valid only with req_fulfilled.
  - A misaligned request still takes LATENCY cycles.
  - It fulfils with req_error=1, performs no write, and sets req_loaded_word to 0.
  - Aligned requests give req_error=0.
- Undefined: no req_error port; misaligned accesses are aligned down silently.

Test Plan (LATENCY=2, MEM_BYTES=4096):
1. STORE WORD 0xDEADBEEF @0x100 accepted cycle 0 → req_fulfilled in cycle 2 only; then LOAD WORD @0x100 → req_loaded_word 0xDEADBEEF with req_fulfilled.
2. After test 1: STORE BYTE 0x000000AA @0x101; then:
   - LOAD WORD @0x100 → 0xDEADAAEF.
   - LOAD BYTE @0x103 → 0x000000DE.
   - LOAD HALF @0x102 → 0x0000DEAD.
3. STORE WORD 0x12345678 @0x1100; LOAD WORD @0x100 → 0x12345678 (address wrap).
4. req_valid held high across two LOADs, accepted cycles 0 and 3 → req_fulfilled pulses in cycles 2 and 5 only.
5. STORE WORD 0xCAFEF00D @0x200 accepted cycle 0, rst_n low in cycle 1 → no req_fulfilled; after reset, LOAD WORD @0x200 returns the prior contents.
6. LOAD WORD @0x102 after test 1:
   - Macro undefined → 0xDEADBEEF (aligned to 0x100).
   - Macro defined → req_error=1, req_loaded_word=0.

Source files
------------

// File: rtl/memory_server_if.sv
// Request bus between a processor requester (fetch or load/store unit) and
// memory_server. Building with MEMORY_SERVER_MISALIGN_ERR_EN defined adds the
// req_error response bit to the bus.
package memory_server_pkg;
  typedef enum logic {LOAD = 1'b0, STORE = 1'b1} memory_operation_e;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} memory_operation_size_e;
endpackage

interface memory_server_if #(
  parameter int XLEN = 32
);
  import memory_server_pkg::*;

  logic [XLEN-1:0]        req_address;
  memory_operation_e      req_operation;
  memory_operation_size_e req_size;
  logic [XLEN-1:0]        req_store_word;
  logic                   req_valid;
  logic [XLEN-1:0]        req_loaded_word;
  logic                   req_fulfilled;
`ifdef MEMORY_SERVER_MISALIGN_ERR_EN
  logic                   req_error;

  modport master (
    output req_address, req_operation, req_size, req_store_word, req_valid,
    input  req_loaded_word, req_fulfilled, req_error
  );

  modport slave (
    input  req_address, req_operation, req_size, req_store_word, req_valid,
    output req_loaded_word, req_fulfilled, req_error
  );
`else
  modport master (
    output req_address, req_operation, req_size, req_store_word, req_valid,
    input  req_loaded_word, req_fulfilled
  );

  modport slave (
    input  req_address, req_operation, req_size, req_store_word, req_valid,
    output req_loaded_word, req_fulfilled
  );
`endif
endinterface

// File: rtl/memory_server.sv
// memory_server: byte-addressed, little-endian RAM behind the processor
// request bus. One request at a time, fixed LATENCY cycles from accept to the
// req_fulfilled pulse. Addresses wrap modulo MEM_BYTES.
// Optional feature macro MEMORY_SERVER_MISALIGN_ERR_EN: misaligned requests
// complete with req_error=1, no write and a zero load word; without it the
// low address bits are dropped so accesses are aligned down.
module memory_server
  import memory_server_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MEM_BYTES = 4096,
  parameter int LATENCY   = 2,
  parameter     INIT_FILE = ""
) (
  input  logic           clk,
  input  logic           rst_n,
  memory_server_if.slave bus
);

  localparam int WORDS = MEM_BYTES / 4;
  localparam int WAW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  // Control state (reset)
  state_e                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_fulfilled;
  logic [XLEN-1:0]        r_loaded;
`ifdef MEMORY_SERVER_MISALIGN_ERR_EN
  logic                   r_error;
`endif

  // Latched request (not reset)
  memory_operation_e      r_op;
  memory_operation_size_e r_size;
  logic [WAW-1:0]         r_idx;
  logic [1:0]             r_off;
  logic [31:0]            r_wdata;
  logic                   r_mis;

  // Storage: one 32-bit little-endian word per entry, byte lanes [8k+7:8k]
  logic [31:0]            r_mem [WORDS];

  logic [1:0]             w_acc_off;
  logic                   w_acc_mis;
  logic [WAW-1:0]         w_rd_idx;
  logic [1:0]             w_rd_off;
  memory_operation_size_e w_rd_size;
  memory_operation_e      w_rd_op;
  logic                   w_rd_mis;
  logic [31:0]            w_rd_word;
  logic                   w_resp_load;
  logic [XLEN-1:0]        w_resp_val;
  logic                   w_resp_err;
  logic                   w_commit;
  logic [3:0]             w_be;
  logic [31:0]            w_st_data;

  function automatic logic [WAW-1:0] word_index(input logic [XLEN-1:0] addr);
    return WAW'((addr >> 2) & XLEN'(WORDS - 1));
  endfunction

  function automatic logic misaligned(input memory_operation_size_e size, input logic [1:0] off);
    return ((size == HALF) && off[0]) || ((size == WORD) && (off != 2'b00));
  endfunction

  function automatic logic [1:0] align_down(input memory_operation_size_e size, input logic [1:0] off);
    logic [1:0] v;
    case (size)
      HALF:    v = {off[1], 1'b0};
      WORD:    v = 2'b00;
      default: v = off;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input memory_operation_size_e size);
    logic [31:0] v;
    case (size)
      BYTE:    v = {24'd0, word[{off, 3'b000} +: 8]};
      HALF:    v = {16'd0, word[{off[1], 4'b0000} +: 16]};
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] store_be(input memory_operation_size_e size, input logic [1:0] off);
    logic [3:0] v;
    case (size)
      BYTE:    v = 4'b0001 << off;
      HALF:    v = 4'b0011 << {off[1], 1'b0};
      default: v = 4'b1111;
    endcase
    return v;
  endfunction

  // Replicating the low bits across lanes lets the byte enables pick the right copy.
  function automatic logic [31:0] store_data(input memory_operation_size_e size, input logic [31:0] wd);
    logic [31:0] v;
    case (size)
      BYTE:    v = {4{wd[7:0]}};
      HALF:    v = {2{wd[15:0]}};
      default: v = wd;
    endcase
    return v;
  endfunction

  // Classify the request on the bus: byte offset and misalignment at accept time.
  always_comb begin
    w_acc_off = bus.req_address[1:0];
    w_acc_mis = 1'b0;
`ifdef MEMORY_SERVER_MISALIGN_ERR_EN
    w_acc_mis = misaligned(bus.req_size, bus.req_address[1:0]);
`else
    w_acc_off = align_down(bus.req_size, bus.req_address[1:0]);
`endif
  end

  // Response value, computed on the cycle that enters RESP (live bus when LATENCY=1).
  always_comb begin
    w_rd_idx  = r_idx;
    w_rd_off  = r_off;
    w_rd_size = r_size;
    w_rd_op   = r_op;
    w_rd_mis  = r_mis;
    if (r_state == ST_IDLE) begin
      w_rd_idx  = word_index(bus.req_address);
      w_rd_off  = w_acc_off;
      w_rd_size = bus.req_size;
      w_rd_op   = bus.req_operation;
      w_rd_mis  = w_acc_mis;
    end
    w_rd_word   = r_mem[w_rd_idx];
    w_resp_err  = w_rd_mis;
    w_resp_load = (w_rd_op == LOAD) || w_rd_mis;
    w_resp_val  = w_rd_mis ? '0 : XLEN'(load_extract(w_rd_word, w_rd_off, w_rd_size));
  end

  // Store lanes and commit strobe for the RESP cycle.
  always_comb begin
    w_be      = r_mis ? 4'b0000 : store_be(r_size, r_off);
    w_st_data = store_data(r_size, r_wdata);
    w_commit  = (r_state == ST_RESP) && (r_op == STORE);
  end

  // Request FSM: accept in IDLE, count down in WAIT, pulse req_fulfilled in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_fulfilled <= 1'b0;
      r_loaded    <= '0;
`ifdef MEMORY_SERVER_MISALIGN_ERR_EN
      r_error     <= 1'b0;
`endif
    end else begin
      r_fulfilled <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            if (LATENCY == 1) begin
              r_state     <= ST_RESP;
              r_fulfilled <= 1'b1;
              if (w_resp_load) r_loaded <= w_resp_val;
`ifdef MEMORY_SERVER_MISALIGN_ERR_EN
              r_error     <= w_resp_err;
`endif
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CW'(LATENCY - 2);
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= ST_RESP;
            r_fulfilled <= 1'b1;
            if (w_resp_load) r_loaded <= w_resp_val;
`ifdef MEMORY_SERVER_MISALIGN_ERR_EN
            r_error     <= w_resp_err;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
`ifdef MEMORY_SERVER_MISALIGN_ERR_EN
          r_error <= 1'b0;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Capture the request fields on accept; later bus changes are ignored.
  always_ff @(posedge clk) begin
    if ((r_state == ST_IDLE) && bus.req_valid) begin
      r_op    <= bus.req_operation;
      r_size  <= bus.req_size;
      r_idx   <= word_index(bus.req_address);
      r_off   <= w_acc_off;
      r_wdata <= bus.req_store_word[31:0];
      r_mis   <= w_acc_mis;
    end
  end

  // RAM write port: store commits at the end of RESP, only the enabled byte lanes.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[r_idx][8*k +: 8] <= w_st_data[8*k +: 8];
      end
    end
  end

  assign bus.req_loaded_word = r_loaded;
  assign bus.req_fulfilled   = r_fulfilled;
`ifdef MEMORY_SERVER_MISALIGN_ERR_EN
  assign bus.req_error       = r_error;
`endif

endmodule

// File: tb/tb_memory_server.sv
// Randomized scoreboard bench for memory_server (LATENCY=2, MEM_BYTES=4096).
// The reference model is a plain byte array updated when each request is issued.
`timescale 1ns/1ps
module tb_memory_server;
  import memory_server_pkg::*;

  localparam int XLEN      = 32;
  localparam int MEM_BYTES = 4096;
  localparam int LATENCY   = 2;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  memory_server_if #(.XLEN(XLEN)) bus();

  memory_server #(
    .XLEN(XLEN), .MEM_BYTES(MEM_BYTES), .LATENCY(LATENCY), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  bit   held = 1'b0;
  exp_t q[$];

  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] last_load = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference behaviour: little-endian byte RAM, address mod MEM_BYTES.
  task automatic model_req(input memory_operation_e op, input memory_operation_size_e sz,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] d, output logic err);
    int unsigned a, n;
    a   = addr % MEM_BYTES;
    n   = (sz == BYTE) ? 1 : (sz == HALF) ? 2 : 4;
    err = 1'b0;
    d   = 32'd0;
    if ((a % n) != 0) begin
`ifdef MEMORY_SERVER_MISALIGN_ERR_EN
      err       = 1'b1;
      last_load = 32'd0;
      return;
`else
      a = a - (a % n);
`endif
    end
    if (op == STORE) begin
      for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
      d = last_load;
    end else begin
      for (int i = 0; i < n; i++) d[8*i +: 8] = ref_mem[a + i];
      last_load = d;
    end
  endtask

  // Issue one request; hold keeps req_valid high into the next request.
  task automatic send(input memory_operation_e op, input memory_operation_size_e sz,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input bit hold, input bit scramble);
    exp_t e;
    int   k;
    bit   seen;
    if (!held) @(negedge clk);
    k = held ? cyc + 1 : cyc;
    bus.req_operation  = op;
    bus.req_size       = sz;
    bus.req_address    = addr;
    bus.req_store_word = wd;
    bus.req_valid      = 1'b1;
    model_req(op, sz, addr, wd, e.data, e.err);
    e.cyc = k + LATENCY;
    q.push_back(e);
    if (held) @(negedge clk);
    seen = 1'b0;
    for (int i = 0; i < LATENCY + 6 && !seen; i++) begin
      @(negedge clk);
      seen = bus.req_fulfilled;
      if (!seen && scramble) begin
        bus.req_address    = $urandom;
        bus.req_store_word = $urandom;
        bus.req_operation  = memory_operation_e'($urandom_range(0, 1));
        bus.req_valid      = $urandom_range(0, 1) == 1;
      end
    end
    if (!seen) begin
      checks++;
      $display("FAIL fulfil_timeout: got no req_fulfilled, expected one by cycle %0d", e.cyc);
    end
    if (!hold) bus.req_valid = 1'b0;
    held = hold;
  endtask

  // Monitor: every req_fulfilled pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.req_fulfilled) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_fulfilled: got 1 at cycle %0d, expected 0", cyc);
        end else begin
          e = q.pop_front();
          chk("fulfil_cycle", 64'(cyc), 64'(e.cyc));
          chk("loaded_word", 64'(bus.req_loaded_word), 64'(e.data));
`ifdef MEMORY_SERVER_MISALIGN_ERR_EN
          chk("req_error", 64'(bus.req_error), 64'(e.err));
`endif
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    bus.req_address    = '0;
    bus.req_operation  = LOAD;
    bus.req_size       = WORD;
    bus.req_store_word = '0;
    bus.req_valid      = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_fulfilled", 64'(bus.req_fulfilled), 64'd0);
    chk("reset_loaded", 64'(bus.req_loaded_word), 64'd0);
    rst_n = 1'b1;

    // Fill the working window 0x000-0x3FF plus the top word
    for (int w = 0; w < 256; w++) send(STORE, WORD, 32'(w * 4), $urandom, w[0], 1'b0);
    send(STORE, WORD, 32'(MEM_BYTES - 4), 32'hA1B2C3D4, 1'b0, 1'b0);
    send(LOAD, WORD, 32'(MEM_BYTES - 4), 32'd0, 1'b0, 1'b0);
    send(LOAD, BYTE, 32'(MEM_BYTES - 1), 32'd0, 1'b0, 1'b0);

    // Word store/load, byte merge, sub-word loads
    send(STORE, WORD, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0);
    send(LOAD,  WORD, 32'h100, 32'd0, 1'b0, 1'b0);
    send(STORE, BYTE, 32'h101, 32'h000000AA, 1'b0, 1'b0);
    send(LOAD,  WORD, 32'h100, 32'd0, 1'b0, 1'b0);
    send(LOAD,  BYTE, 32'h103, 32'd0, 1'b0, 1'b0);
    send(LOAD,  HALF, 32'h102, 32'd0, 1'b0, 1'b0);
    send(LOAD,  WORD, 32'h102, 32'd0, 1'b0, 1'b0);
    send(STORE, HALF, 32'h101, 32'hFFFF1234, 1'b0, 1'b0);
    send(LOAD,  WORD, 32'h100, 32'd0, 1'b0, 1'b0);
    send(STORE, BYTE, 32'h3FF, 32'h0000005A, 1'b0, 1'b0);
    send(LOAD,  WORD, 32'h3FC, 32'd0, 1'b0, 1'b0);

    // Address wrap
    send(STORE, WORD, 32'h1100, 32'h12345678, 1'b0, 1'b0);
    send(LOAD,  WORD, 32'h100, 32'd0, 1'b0, 1'b0);

    // req_valid held across two loads
    send(LOAD, WORD, 32'h100, 32'd0, 1'b1, 1'b0);
    send(LOAD, HALF, 32'h204, 32'd0, 1'b0, 1'b0);

    // Reset during a store: no pulse, store discarded
    @(negedge clk);
    bus.req_operation  = STORE;
    bus.req_size       = WORD;
    bus.req_address    = 32'h200;
    bus.req_store_word = 32'hCAFEF00D;
    bus.req_valid      = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_fulfilled", 64'(bus.req_fulfilled), 64'd0);
    chk("midreset_loaded", 64'(bus.req_loaded_word), 64'd0);
    rst_n = 1'b1;
    last_load = 32'd0;
    repeat (3) @(negedge clk);
    send(LOAD, WORD, 32'h200, 32'd0, 1'b0, 1'b0);

    // Randomized traffic with aliased upper address bits and noise after accept
    for (int n = 0; n < 300; n++) begin
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 1023));
      send(memory_operation_e'($urandom_range(0, 1)),
           memory_operation_size_e'($urandom_range(0, 2)),
           a, $urandom, ($urandom_range(0, 1) == 1) && (n != 299),
           $urandom_range(0, 3) == 0);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
